// File: rtl/data_ram_ctrl.sv
// Data-side memory responder for the MEM stage: a byte-lane-writable word RAM
// and a small COUNT/COMPARE/CTRL timer region that raises a registered interrupt.
module data_ram_ctrl #(
  parameter int          ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = 16'hBFD0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_int_o
);

  localparam logic [15:0] OFF_COUNT   = 16'h0000;
  localparam logic [15:0] OFF_COMPARE = 16'h0004;
  localparam logic [15:0] OFF_CTRL    = 16'h0008;

  logic [31:0] mem [2**ADDR_W];

  logic              mmio;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       off;
  logic              ram_wr;
  logic              mmio_wr;
  logic [31:0]       wmask;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;

  always_comb begin
    mmio    = (addr[31:16] == MMIO_HI);
    idx     = addr[ADDR_W+1:2];
    off     = addr[15:0];
    ram_wr  = ce & we & ~rst & ~mmio;
    mmio_wr = ce & we & mmio;
    for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{sel[k]}};
  end

  // RAM is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_wr && sel[k]) mem[idx][8*k +: 8] <= data_i[8*k +: 8];
    end
  end

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    en_d      = en_q;
    pend_d    = pend_q;
    if (mmio_wr) begin
      case (off)
        OFF_COUNT:   count_d   = (count_q & ~wmask) | (data_i & wmask);
        OFF_COMPARE: compare_d = (compare_q & ~wmask) | (data_i & wmask);
        OFF_CTRL: begin
          if (sel[0]) begin
            en_d = data_i[0];
            if (data_i[1]) pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    // Match uses pre-edge values and overrides a same-cycle W1C.
    if (en_q && (count_q == compare_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
    end
  end

  assign timer_int_o = pend_q;

  always_comb begin
    data_o = 32'd0;
    if (!rst && ce && !we) begin
      if (mmio) begin
        case (off)
          OFF_COUNT:   data_o = count_q;
          OFF_COMPARE: data_o = compare_q;
          OFF_CTRL:    data_o = {30'd0, pend_q, en_q};
          default:     data_o = 32'd0;
        endcase
      end else begin
        data_o = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: expected load data is queued as each step
// is driven and popped/compared mid-cycle against data_o.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_count;
  logic [31:0] cmp;

  localparam logic [31:0] A_COUNT   = 32'hBFD0_0000;
  localparam logic [31:0] A_COMPARE = 32'hBFD0_0004;
  localparam logic [31:0] A_CTRL    = 32'hBFD0_0008;
  localparam logic [31:0] A_OTHER   = 32'hBFD0_000C;

  data_ram_ctrl #(.ADDR_W(10), .MMIO_HI(16'hBFD0)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .we          (we),
    .addr        (addr),
    .sel         (sel),
    .data_i      (data_i),
    .data_o      (data_o),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // One bus cycle: drive, sample at the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input logic r, input logic c, input logic w,
                      input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_data, input logic exp_int);
    logic [31:0] exp_v;
    rst = r; ce = c; we = w; addr = a; sel = s; data_i = d;
    exp_q.push_back(exp_data);
    #4;
    exp_v = exp_q.pop_front();
    checks++;
    assert (data_o === exp_v) else begin
      errors++;
      $error("FAIL %s data_o: observed %08h expected %08h", tag, data_o, exp_v);
    end
    checks++;
    assert (timer_int_o === exp_int) else begin
      errors++;
      $error("FAIL %s timer_int_o: observed %0b expected %0b", tag, timer_int_o, exp_int);
    end
    if (r) m_count = 32'd0;
    else if (c && w && a == A_COUNT) m_count = lane_merge(m_count, d, s);
    else m_count = m_count + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
    m_count = '0;
    repeat (2) @(posedge clk);
    #1;

    step("reset_read",   1, 1, 0, A_COUNT, 4'hF, 0, 32'h0, 0);
    step("count_first",  0, 1, 0, A_COUNT, 4'hF, 0, m_count, 0);
    step("sw_word",      0, 1, 1, 32'h10, 4'b1111, 32'h1234_5678, 32'h0, 0);
    step("lw_word",      0, 1, 0, 32'h10, 4'b1111, 0, 32'h1234_5678, 0);
    step("ce_low",       0, 0, 0, 32'h10, 4'b1111, 0, 32'h0, 0);
    step("sb_lane",      0, 1, 1, 32'h11, 4'b0100, 32'hAAAA_AAAA, 32'h0, 0);
    step("lw_lane",      0, 1, 0, 32'h10, 4'b1111, 0, 32'h12AA_5678, 0);
    step("sel_zero_wr",  0, 1, 1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0);
    step("lw_sel_zero",  0, 1, 0, 32'h10, 4'b1111, 0, 32'h12AA_5678, 0);
    step("sw_word3",     0, 1, 1, 32'hC, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
    step("rst_wr",       1, 1, 1, 32'hC, 4'b1111, 32'h1111_1111, 32'h0, 0);
    step("count_post_rst", 0, 1, 0, A_COUNT, 4'hF, 0, 32'h0, 0);
    step("lw_word3",     0, 1, 0, 32'hC, 4'b1111, 0, 32'hDEAD_BEEF, 0);
    step("lw_alias",     0, 1, 0, 32'h100C, 4'b1111, 0, 32'hDEAD_BEEF, 0);

    cmp = m_count + 32'd2;
    step("wr_compare",   0, 1, 1, A_COMPARE, 4'b1111, cmp, 32'h0, 0);
    step("wr_ctrl_en",   0, 1, 1, A_CTRL, 4'b1111, 32'h1, 32'h0, 0);
    step("match_cycle",  0, 1, 0, A_COUNT, 4'hF, 0, cmp, 0);
    step("ctrl_pend",    0, 1, 0, A_CTRL, 4'hF, 0, 32'h3, 1);
    step("w1c_nomatch",  0, 1, 1, A_CTRL, 4'b0001, 32'h3, 32'h0, 1);
    step("ctrl_cleared", 0, 1, 0, A_CTRL, 4'hF, 0, 32'h1, 0);

    cmp = m_count + 32'd2;
    step("wr_compare2",  0, 1, 1, A_COMPARE, 4'b1111, cmp, 32'h0, 0);
    step("rd_compare",   0, 1, 0, A_COMPARE, 4'hF, 0, cmp, 0);
    step("w1c_on_match", 0, 1, 1, A_CTRL, 4'b0001, 32'h3, 32'h0, 0);
    step("set_wins",     0, 1, 0, A_CTRL, 4'hF, 0, 32'h3, 1);
    step("en_off",       0, 1, 1, A_CTRL, 4'b0001, 32'h0, 32'h0, 1);
    step("pend_kept",    0, 1, 0, A_CTRL, 4'hF, 0, 32'h2, 1);
    step("wr_other",     0, 1, 1, A_OTHER, 4'b1111, 32'h5555_5555, 32'h0, 1);
    step("rd_other",     0, 1, 0, A_OTHER, 4'hF, 0, 32'h0, 1);
    step("compare_kept", 0, 1, 0, A_COMPARE, 4'hF, 0, cmp, 1);

    step("wr_count",     0, 1, 1, A_COUNT, 4'b1111, 32'hFFFF_FFFE, 32'h0, 1);
    step("count_fffe",   0, 1, 0, A_COUNT, 4'hF, 0, 32'hFFFF_FFFE, 1);
    step("count_ffff",   0, 1, 0, A_COUNT, 4'hF, 0, 32'hFFFF_FFFF, 1);
    step("count_wrap",   0, 1, 0, A_COUNT, 4'hF, 0, 32'h0000_0000, 1);
    step("wr_count_lo",  0, 1, 1, A_COUNT, 4'b0001, 32'h0000_00AB, 32'h0, 1);
    step("count_lo",     0, 1, 0, A_COUNT, 4'hF, 0, 32'h0000_00AB, 1);
    step("count_inc",    0, 1, 0, A_COUNT, 4'hF, 0, 32'h0000_00AC, 1);
    step("count_model",  0, 1, 0, A_COUNT, 4'hF, 0, m_count, 1);

    step("rst_again",    1, 1, 0, A_CTRL, 4'hF, 0, 32'h0, 1);
    step("ctrl_reset",   0, 1, 0, A_CTRL, 4'hF, 0, 32'h0, 0);
    step("compare_reset", 0, 1, 0, A_COMPARE, 4'hF, 0, 32'hFFFF_FFFF, 0);
    step("lw_after_rst2", 0, 1, 0, 32'h10, 4'hF, 0, 32'h12AA_5678, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
